// File: rtl/xor_add_decryptor.sv
// ---------------------------------------------------------------------------
// xor_add_decryptor
//
// Byte-serial decryption engine for the mini crypto processor. It undoes the
// ADD/XOR round cipher: encryption applies x = (x ^ k_r) + k_r for rounds
// r = 0..ROUNDS-1, so decryption walks the rounds backwards and applies
// x = x - k_r followed by x = x ^ k_r. Each round takes two clocks (SUB, then
// XOR). All arithmetic is 8-bit wrap-around.
//
// The round key k_r is the key snapshot rotated left by r bit positions.
//
// Ports:
//   clk        system clock, rising edge
//   rst_n      asynchronous active-low reset
//   key_we     key register write strobe (honoured in every state)
//   key_in     key value loaded on key_we
//   in_valid   ciphertext byte present
//   in_ready   engine can accept a byte (IDLE only)
//   in_data    ciphertext byte
//   out_valid  plaintext byte present (DONE only)
//   out_ready  sink accepts the plaintext
//   out_data   plaintext byte, held until the next result is produced
//   flush      synchronous abort back to IDLE, overrides every transition
//   busy       high whenever the engine is not in IDLE
// ---------------------------------------------------------------------------
module xor_add_decryptor #(
    parameter int ROUNDS = 2,
    parameter int WIDTH  = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             key_we,
    input  logic [WIDTH-1:0] key_in,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    input  logic             flush,
    output logic             busy
);

    // Round counter is wide enough for ROUNDS up to 8 (indices 0..7).
    localparam int            RW         = 3;
    localparam logic [RW-1:0] LAST_ROUND = RW'(ROUNDS - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SUB  = 2'd1,
        ST_XOR  = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    state_t           state;
    state_t           state_next;

    logic [WIDTH-1:0] key_reg;
    logic [WIDTH-1:0] key_snap;
    logic [WIDTH-1:0] work;
    logic [RW-1:0]    round;
    logic [WIDTH-1:0] out_data_q;

    logic [2*WIDTH-1:0] key_dbl;
    logic [WIDTH-1:0]   k_round;
    logic               accept;
    logic               last_xor;

    // The round key is a left rotation of the snapshot by the current round
    // index. Shifting a doubled copy of the key and taking the upper half
    // gives the rotation without a mux tree; the round index never exceeds
    // 7, so it is already the rotation amount modulo 8.
    always_comb begin
        key_dbl = {key_snap, key_snap} << round;
        k_round = key_dbl[2*WIDTH-1:WIDTH];
    end

    // A byte is taken only from IDLE and never on a flush cycle. last_xor
    // marks the final XOR step, whose result becomes the plaintext.
    always_comb begin
        accept   = (state == ST_IDLE) && in_valid && !flush;
        last_xor = (state == ST_XOR) && (round == '0) && !flush;
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic. flush wins over every other transition, including
    // a pending accept in IDLE or a drain in DONE. DONE never accepts a new
    // byte directly; the engine always passes through IDLE first.
    always_comb begin
        state_next = state;
        if (flush) begin
            state_next = ST_IDLE;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (in_valid) begin
                        state_next = ST_SUB;
                    end
                end
                ST_SUB: begin
                    state_next = ST_XOR;
                end
                ST_XOR: begin
                    if (round == '0) begin
                        state_next = ST_DONE;
                    end else begin
                        state_next = ST_SUB;
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        state_next = ST_IDLE;
                    end
                end
                default: begin
                    state_next = ST_IDLE;
                end
            endcase
        end
    end

    // Output decode. All handshake outputs depend on state alone, so none of
    // them combinationally follows the input handshakes.
    always_comb begin
        in_ready  = (state == ST_IDLE);
        out_valid = (state == ST_DONE);
        busy      = (state != ST_IDLE);
        out_data  = out_data_q;
    end

    // Key register. It can be rewritten at any time; the byte in flight is
    // protected because it works from key_snap, not from key_reg.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            key_reg <= '0;
        end else if (key_we) begin
            key_reg <= key_in;
        end
    end

    // Working datapath. On accept the ciphertext is loaded, the round index
    // starts at the last round and the current key is snapshotted; a key
    // write on the same edge therefore lands in key_reg only and the byte
    // uses the previous key. SUB and XOR then alternate, counting the round
    // down after each XOR. A flush just clears the round index.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            work     <= '0;
            round    <= '0;
            key_snap <= '0;
        end else if (flush) begin
            round <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        work     <= in_data;
                        round    <= LAST_ROUND;
                        key_snap <= key_reg;
                    end
                end
                ST_SUB: begin
                    work <= work - k_round;
                end
                ST_XOR: begin
                    work <= work ^ k_round;
                    if (round != '0) begin
                        round <= round - RW'(1);
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Plaintext holding register. It captures the result of the final XOR
    // as the engine enters DONE and then keeps that value through the drain
    // and the following operation, so the sink sees a stable byte until the
    // next result replaces it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_data_q <= '0;
        end else if (last_xor) begin
            out_data_q <= work ^ k_round;
        end
    end

endmodule

// File: tb/tb_xor_add_decryptor.sv
// ---------------------------------------------------------------------------
// tb_xor_add_decryptor
//
// Bench for xor_add_decryptor with ROUNDS=2. A transaction-level model
// (decrypt as plain integer arithmetic, plus a small busy/countdown tracker)
// predicts the handshake outputs every cycle; directed sequences cover the
// worked examples, backpressure, mid-operation key writes, flush and
// asynchronous reset, followed by a randomized phase.
// ---------------------------------------------------------------------------
module tb_xor_add_decryptor;

    localparam int ROUNDS = 2;
    localparam int WIDTH  = 8;

    logic             clk       = 1'b0;
    logic             rst_n     = 1'b1;
    logic             key_we    = 1'b0;
    logic [WIDTH-1:0] key_in    = '0;
    logic             in_valid  = 1'b0;
    logic [WIDTH-1:0] in_data   = '0;
    logic             out_ready = 1'b0;
    logic             flush     = 1'b0;
    logic             in_ready;
    logic             out_valid;
    logic [WIDTH-1:0] out_data;
    logic             busy;

    int totalCount = 0;
    int badCount   = 0;
    bit compareOn  = 1'b0;

    // Model state: whether a byte is in flight, edges elapsed since accept,
    // the pending result and the visible output.
    bit         mBusy     = 1'b0;
    bit         mOutValid = 1'b0;
    int         mCount    = 0;
    logic [7:0] mKey      = 8'h00;
    logic [7:0] mResult   = 8'h00;
    logic [7:0] mOutData  = 8'h00;

    always #5 clk = ~clk;

    xor_add_decryptor #(.ROUNDS(ROUNDS), .WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .key_we    (key_we),
        .key_in    (key_in),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .flush     (flush),
        .busy      (busy)
    );

    // Rotate left one bit at a time, r times.
    function automatic logic [7:0] rotl(input logic [7:0] k, input int r);
        logic [7:0] v = k;
        for (int i = 0; i < (r % 8); i++) begin
            v = {v[6:0], v[7]};
        end
        return v;
    endfunction

    function automatic logic [7:0] decrypt(input logic [7:0] key, input logic [7:0] c);
        int x = int'(c);
        for (int r = ROUNDS - 1; r >= 0; r--) begin
            x = (x - int'(rotl(key, r)) + 256) % 256;
            x = x ^ int'(rotl(key, r));
        end
        return 8'(x);
    endfunction

    function automatic logic [7:0] encrypt(input logic [7:0] key, input logic [7:0] p);
        int x = int'(p);
        for (int r = 0; r < ROUNDS; r++) begin
            x = ((x ^ int'(rotl(key, r))) + int'(rotl(key, r))) % 256;
        end
        return 8'(x);
    endfunction

    task automatic checkOutput(input string name, input logic [7:0] actual, input logic [7:0] expected);
        totalCount++;
        if (actual !== expected) begin
            badCount++;
            $display("[TB] FAIL %s: got %h expected %h at %0t", name, actual, expected, $time);
        end
    endtask

    // Behavioural model, advanced on every clock edge from the sampled
    // inputs. Priority: flush, then accept from idle, then countdown, then
    // drain. The key write is applied last so an accept on the same edge
    // uses the previous key.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mBusy     <= 1'b0;
            mOutValid <= 1'b0;
            mCount    <= 0;
            mKey      <= 8'h00;
            mResult   <= 8'h00;
            mOutData  <= 8'h00;
        end else begin
            if (flush) begin
                mBusy     <= 1'b0;
                mOutValid <= 1'b0;
            end else if (!mBusy && in_valid) begin
                mBusy   <= 1'b1;
                mCount  <= 0;
                mResult <= decrypt(mKey, in_data);
            end else if (mBusy && !mOutValid) begin
                mCount <= mCount + 1;
                if (mCount + 1 == 2 * ROUNDS) begin
                    mOutValid <= 1'b1;
                    mOutData  <= mResult;
                end
            end else if (mOutValid && out_ready) begin
                mBusy     <= 1'b0;
                mOutValid <= 1'b0;
            end
            if (key_we) begin
                mKey <= key_in;
            end
        end
    end

    // Compare process: every falling edge outside reset, all outputs are
    // checked against the model.
    always @(negedge clk) begin
        if (rst_n && compareOn) begin
            checkOutput("cmp_in_ready", {7'd0, in_ready}, {7'd0, !mBusy});
            checkOutput("cmp_busy", {7'd0, busy}, {7'd0, mBusy});
            checkOutput("cmp_out_valid", {7'd0, out_valid}, {7'd0, mOutValid});
            checkOutput("cmp_out_data", out_data, mOutData);
        end
    end

    task automatic writeKey(input logic [7:0] k);
        @(negedge clk);
        key_we = 1'b1;
        key_in = k;
        @(negedge clk);
        key_we = 1'b0;
    endtask

    // Wait (bounded) for out_valid, return the number of negedges seen.
    task automatic waitValid(output int latency, output bit ok);
        latency = 1;
        while (!out_valid && latency < 60) begin
            @(negedge clk);
            latency++;
        end
        ok = out_valid;
        if (!ok) begin
            checkOutput("out_valid_timeout", {7'd0, out_valid}, 8'd1);
        end
    endtask

    // Hold the result for 'stall' cycles checking it stays put, then drain.
    task automatic drain(input int stall, input logic [7:0] result);
        for (int i = 0; i < stall; i++) begin
            @(negedge clk);
            checkOutput("hold_valid", {7'd0, out_valid}, 8'd1);
            checkOutput("hold_data", out_data, result);
            checkOutput("hold_in_ready", {7'd0, in_ready}, 8'd0);
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        checkOutput("drain_in_ready", {7'd0, in_ready}, 8'd1);
        checkOutput("drain_valid", {7'd0, out_valid}, 8'd0);
    endtask

    // Offer one byte, measure the accept-to-valid latency, check the
    // plaintext and drain after 'stall' cycles of backpressure.
    task automatic applyStimulus(input logic [7:0] data, input int stall, input logic [7:0] expOut);
        int guard = 0;
        int latency;
        bit ok;
        @(negedge clk);
        while (!in_ready && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        in_valid = 1'b1;
        in_data  = data;
        @(negedge clk);
        in_valid = 1'b0;
        waitValid(latency, ok);
        if (ok) begin
            // negedge count minus one is the number of edges after accept
            checkOutput("latency_edges", 8'(latency - 1), 8'(2 * ROUNDS));
            checkOutput("plaintext", out_data, expOut);
            drain(stall, expOut);
        end
    endtask

    initial begin
        int lat;
        bit ok;
        $display("[TB] start, ROUNDS=%0d", ROUNDS);

        // Model pins against hand-computed values.
        checkOutput("model_3C_39", decrypt(8'h3C, 8'h39), 8'h41);
        checkOutput("model_FF_00", decrypt(8'hFF, 8'h00), 8'h00);
        checkOutput("model_00_A5", decrypt(8'h00, 8'hA5), 8'hA5);
        checkOutput("model_11_39", decrypt(8'h11, 8'h39), 8'h35);
        checkOutput("model_enc_3C_41", encrypt(8'h3C, 8'h41), 8'h39);

        // Reset state.
        #1 rst_n = 1'b0;
        #2;
        checkOutput("rst_out_valid", {7'd0, out_valid}, 8'd0);
        checkOutput("rst_out_data", out_data, 8'h00);
        checkOutput("rst_busy", {7'd0, busy}, 8'd0);
        #9 rst_n = 1'b1;
        @(negedge clk);
        checkOutput("rel_in_ready", {7'd0, in_ready}, 8'd1);
        checkOutput("rel_busy", {7'd0, busy}, 8'd0);
        compareOn = 1'b1;

        // Identity with the reset key.
        applyStimulus(8'hA5, 0, 8'hA5);

        // Worked example with backpressure.
        writeKey(8'h3C);
        applyStimulus(8'h39, 5, 8'h41);

        // Wrap and borrow.
        writeKey(8'hFF);
        applyStimulus(8'h00, 1, 8'h00);

        // Key write while in SUB does not disturb the byte in flight.
        writeKey(8'h3C);
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = 8'h39;
        @(negedge clk);
        in_valid = 1'b0;
        key_we   = 1'b1;
        key_in   = 8'h11;
        @(negedge clk);
        key_we = 1'b0;
        waitValid(lat, ok);
        if (ok) begin
            checkOutput("midkey_plaintext", out_data, 8'h41);
            drain(0, 8'h41);
        end
        applyStimulus(8'h39, 0, 8'h35);

        // flush with in_valid in IDLE: nothing accepted.
        writeKey(8'h3C);
        @(negedge clk);
        flush    = 1'b1;
        in_valid = 1'b1;
        in_data  = 8'h39;
        @(negedge clk);
        flush    = 1'b0;
        in_valid = 1'b0;
        checkOutput("flush_idle_busy", {7'd0, busy}, 8'd0);

        // flush during the XOR of round 1.
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = 8'h39;
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        checkOutput("flush_in_ready", {7'd0, in_ready}, 8'd1);
        checkOutput("flush_busy", {7'd0, busy}, 8'd0);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            checkOutput("flush_no_valid", {7'd0, out_valid}, 8'd0);
        end
        applyStimulus(8'h39, 0, 8'h41);

        // Asynchronous reset mid-round.
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = 8'h00;
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        checkOutput("arst_out_data", out_data, 8'h00);
        checkOutput("arst_busy", {7'd0, busy}, 8'd0);
        checkOutput("arst_out_valid", {7'd0, out_valid}, 8'd0);
        @(negedge clk);
        #2 rst_n = 1'b1;
        applyStimulus(8'h5A, 0, 8'h5A);
        writeKey(8'h3C);
        applyStimulus(8'h39, 2, 8'h41);

        // Randomized traffic, checked by the compare process.
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            key_we    = ($urandom % 8) == 0;
            key_in    = 8'($urandom);
            in_valid  = ($urandom % 2) == 0;
            in_data   = 8'($urandom);
            out_ready = ($urandom % 3) != 0;
            flush     = ($urandom % 20) == 0;
        end
        @(negedge clk);
        key_we    = 1'b0;
        in_valid  = 1'b0;
        flush     = 1'b0;
        out_ready = 1'b1;
        repeat (20) @(negedge clk);
        out_ready = 1'b0;
        compareOn = 1'b0;

        $display("test done: total=%0d bad=%0d", totalCount, badCount);
        $finish;
    end

endmodule
